sensor_readings_axil_v2: RTL and testbench

AXI4-Lite slave that captures samples from `NUM_CH` independent sensor channels into a memory-mapped register file. It is the parametrised successor to the fixed four-register sensor_readings slave. Over the previous slave it adds the following:
- per-channel new-data and overrun flags;
- per-channel sample counters;
- a level interrupt;
- SLVERR on unmapped accesses.

It sits behind the PS AXI interconnect; the sensor front-ends drive its sample ports directly.

---
 rtl/sensor_readings_axil_v2_if.sv | 37 +++
 rtl/sensor_readings_axil_v2.sv | 194 +++++++++++++++++++
 tb/tb_sensor_readings_axil_v2.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_readings_axil_v2_if.sv
// AXI4-Lite bus bundle for the sensor readings slave.
interface sensor_readings_axil_v2_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sensor_readings_axil_v2.sv
// AXI4-Lite slave capturing NUM_CH sensor channels with new/overrun flags,
// per-channel sample counters and a level interrupt.
//
// state  | meaning
// W_IDLE | waiting for AWVALID and WVALID together
// W_ACK  | AWREADY/WREADY pulse, register write applied on this edge
// W_RESP | BVALID held until BREADY
// R_IDLE | waiting for ARVALID
// R_ACK  | ARREADY pulse, RDATA/RRESP registered, clear-on-read applied
// R_RESP | RVALID held until RREADY
module sensor_readings_axil_v2 #(
  parameter int          NUM_CH             = 4,
  parameter int          SAMPLE_W           = 16,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [31:0] VERSION            = 32'h0002_0000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  sensor_readings_axil_v2_if.slave     s_axil,
  input  logic [NUM_CH*SAMPLE_W-1:0]   i_sensor_data,
  input  logic [NUM_CH-1:0]            i_sensor_valid,
  output logic                         o_irq
);
  localparam int          AW         = C_S_AXI_ADDR_WIDTH;
  localparam logic [31:0] DATA_BASE  = 32'd8;
  localparam logic [31:0] COUNT_BASE = 32'(8 + NUM_CH);
  localparam logic [31:0] MAP_END    = 32'(8 + 2 * NUM_CH);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} rd_state_t;

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_rstate, w_rstate_nxt;

  logic [NUM_CH-1:0]   r_ctrl, r_irq_en, r_new, r_ovr;
  logic [SAMPLE_W-1:0] r_data  [NUM_CH];
  logic [31:0]         r_count [NUM_CH];
  logic                r_irq;
  logic [1:0]          r_bresp, r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata;

  logic [31:0]       w_aw_word, w_ar_word;
  logic              w_wr_en, w_rd_en, w_wr_ctrl, w_wr_irq_en, w_wr_status, w_cmd_clr;
  logic [NUM_CH-1:0] w_cap, w_w1c_new, w_w1c_ovr, w_rd_clr;
  logic              w_unused;

  function automatic logic f_mapped(input logic [31:0] word);
    return (word <= 32'd4) || (word >= DATA_BASE && word < MAP_END);
  endfunction

  assign w_aw_word   = 32'(s_axil.awaddr[AW-1:2]);
  assign w_ar_word   = 32'(s_axil.araddr[AW-1:2]);
  assign w_wr_en     = (r_wstate == W_ACK);
  assign w_rd_en     = (r_rstate == R_ACK);
  assign w_wr_ctrl   = w_wr_en && (w_aw_word == 32'd0);
  assign w_wr_irq_en = w_wr_en && (w_aw_word == 32'd1);
  assign w_wr_status = w_wr_en && (w_aw_word == 32'd2);
  assign w_cmd_clr   = w_wr_en && (w_aw_word == 32'd4) && s_axil.wdata[0];
  assign w_w1c_new   = w_wr_status ? s_axil.wdata[NUM_CH-1:0] : '0;
  assign w_w1c_ovr   = w_wr_status ? s_axil.wdata[16 +: NUM_CH] : '0;
  assign w_cap       = i_sensor_valid & r_ctrl;
  assign w_unused    = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0], s_axil.awprot,
                         s_axil.arprot, s_axil.wdata, s_axil.wstrb};

  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      w_rd_clr[k] = w_rd_en && (w_ar_word == DATA_BASE + 32'(k));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt   = r_wstate;
    s_axil.awready = 1'b0;
    s_axil.wready  = 1'b0;
    s_axil.bvalid  = 1'b0;
    case (r_wstate)
      W_IDLE: if (s_axil.awvalid && s_axil.wvalid) w_wstate_nxt = W_ACK;
      W_ACK: begin
        s_axil.awready = 1'b1;
        s_axil.wready  = 1'b1;
        w_wstate_nxt   = W_RESP;
      end
      W_RESP: begin
        s_axil.bvalid = 1'b1;
        if (s_axil.bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt   = r_rstate;
    s_axil.arready = 1'b0;
    s_axil.rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE: if (s_axil.arvalid) w_rstate_nxt = R_ACK;
      R_ACK: begin
        s_axil.arready = 1'b1;
        w_rstate_nxt   = R_RESP;
      end
      R_RESP: begin
        s_axil.rvalid = 1'b1;
        if (s_axil.rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Unmapped words fall through to zero; SLVERR comes from f_mapped.
  always_comb begin
    w_rdata = '0;
    case (w_ar_word)
      32'd0: w_rdata[NUM_CH-1:0] = r_ctrl;
      32'd1: w_rdata[NUM_CH-1:0] = r_irq_en;
      32'd2: begin
        w_rdata[NUM_CH-1:0]  = r_new;
        w_rdata[16 +: NUM_CH] = r_ovr;
      end
      32'd3: w_rdata = VERSION;
      default: ;
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_ar_word == DATA_BASE + 32'(k))  w_rdata[SAMPLE_W-1:0] = r_data[k];
      if (w_ar_word == COUNT_BASE + 32'(k)) w_rdata = r_count[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bresp <= 2'b00;
      r_rresp <= 2'b00;
      r_rdata <= '0;
    end else begin
      if (w_wr_en) r_bresp <= f_mapped(w_aw_word) ? 2'b00 : 2'b10;
      if (w_rd_en) begin
        r_rresp <= f_mapped(w_ar_word) ? 2'b00 : 2'b10;
        r_rdata <= w_rdata;
      end
    end
  end

  // Sets from a capture take priority over W1C and clear-on-read; CMD beats all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctrl   <= '0;
      r_irq_en <= '0;
      r_new    <= '0;
      r_ovr    <= '0;
      r_irq    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_data[k]  <= '0;
        r_count[k] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_CH; b++) begin
        if (w_wr_ctrl && s_axil.wstrb[b/8])   r_ctrl[b]   <= s_axil.wdata[b];
        if (w_wr_irq_en && s_axil.wstrb[b/8]) r_irq_en[b] <= s_axil.wdata[b];
      end
      r_irq <= |(r_new & r_irq_en);
      if (w_cmd_clr) begin
        r_new <= '0;
        r_ovr <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
          r_data[k]  <= '0;
          r_count[k] <= '0;
        end
      end else begin
        r_new <= (r_new & ~w_w1c_new & ~w_rd_clr) | w_cap;
        r_ovr <= (r_ovr & ~w_w1c_ovr) | (w_cap & r_new);
        for (int k = 0; k < NUM_CH; k++) begin
          if (w_cap[k]) begin
            r_data[k]  <= i_sensor_data[k*SAMPLE_W +: SAMPLE_W];
            r_count[k] <= r_count[k] + 32'd1;
          end
        end
      end
    end
  end

  assign s_axil.bresp = r_bresp;
  assign s_axil.rresp = r_rresp;
  assign s_axil.rdata = r_rdata;
  assign o_irq        = r_irq;
endmodule

// File: tb/tb_sensor_readings_axil_v2.sv
// Directed self-checking bench for sensor_readings_axil_v2 (NUM_CH=4, SAMPLE_W=16).
module tb_sensor_readings_axil_v2;
  localparam int          NUM_CH   = 4;
  localparam int          SAMPLE_W = 16;
  localparam logic [31:0] VERSION  = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_CH*SAMPLE_W-1:0] sensor_data  = '0;
  logic [NUM_CH-1:0]          sensor_valid = '0;
  logic irq;
  int   n_checks = 0;
  int   n_pass   = 0;

  sensor_readings_axil_v2_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  sensor_readings_axil_v2 #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(8), .VERSION(VERSION)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .s_axil(bus),
    .i_sensor_data(sensor_data), .i_sensor_valid(sensor_valid), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sample(input int ch, input logic [SAMPLE_W-1:0] val);
    sensor_data[ch*SAMPLE_W +: SAMPLE_W] = val;
  endtask

  task automatic strobe(input logic [NUM_CH-1:0] mask);
    sensor_valid = mask;
    tick();
    sensor_valid = '0;
  endtask

  // cap is driven onto sensor_valid in the cycle whose closing edge applies the write.
  task automatic axil_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [NUM_CH-1:0] cap,
                            output logic [1:0] resp);
    int n;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    tick();
    while (!bus.awready && n < 20) begin tick(); n++; end
    if (!bus.awready) check("aw_timeout", 32'(bus.awready), 32'd1);
    sensor_valid = cap;
    tick();
    sensor_valid = '0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    if (!bus.bvalid) check("b_timeout", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic axil_read(input logic [7:0] addr, input logic [NUM_CH-1:0] cap,
                           output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.araddr = addr; bus.arvalid = 1'b1;
    n = 0;
    tick();
    while (!bus.arready && n < 20) begin tick(); n++; end
    if (!bus.arready) check("ar_timeout", 32'(bus.arready), 32'd1);
    sensor_valid = cap;
    tick();
    sensor_valid = '0;
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin tick(); n++; end
    if (!bus.rvalid) check("r_timeout", 32'(bus.rvalid), 32'd1);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axil_read(addr, '0, d, r);
    check(tag, d, exp);
    check({tag, "_resp"}, 32'(r), 32'd0);
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [NUM_CH-1:0] cap,
                        input logic [1:0] exp_resp);
    logic [1:0] r;
    axil_write(addr, data, strb, cap, r);
    check(tag, 32'(r), 32'(exp_resp));
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          n;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    repeat (3) tick();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    rst_n = 1'b1;
    tick();

    // reset values and basic registers
    rd_chk("rst_ctrl", 8'h00, 32'h0);
    rd_chk("rst_irq_en", 8'h04, 32'h0);
    rd_chk("rst_status", 8'h08, 32'h0);
    rd_chk("id", 8'h0C, VERSION);
    rd_chk("cmd_reads0", 8'h10, 32'h0);
    wr_chk("wr_ctrl", 8'h00, 32'h0000_000F, 4'h1, '0, 2'b00);
    rd_chk("ctrl_rb", 8'h00, 32'hF);
    wr_chk("wr_ctrl_b1", 8'h00, 32'h0000_0000, 4'h2, '0, 2'b00);
    rd_chk("ctrl_strb", 8'h00, 32'hF);

    // single capture and clear-on-read
    set_sample(2, 16'hBEEF);
    strobe(4'b0100);
    rd_chk("st_new2", 8'h08, 32'h4);
    rd_chk("count2", 8'h38, 32'd1);
    rd_chk("data2", 8'h28, 32'h0000_BEEF);
    rd_chk("st_cor", 8'h08, 32'h0);

    // overrun and W1C
    set_sample(0, 16'h0011); strobe(4'b0001);
    set_sample(0, 16'h0022); strobe(4'b0001);
    rd_chk("st_ovr0", 8'h08, 32'h0001_0001);
    wr_chk("w1c_ovr", 8'h08, 32'h0001_0000, 4'h0, '0, 2'b00);
    rd_chk("st_after_w1c", 8'h08, 32'h1);
    rd_chk("data0", 8'h20, 32'h22);
    rd_chk("st_clr0", 8'h08, 32'h0);

    // capture colliding with W1C and with the DATA read edge
    set_sample(1, 16'h1234); strobe(4'b0010);
    rd_chk("st_new1", 8'h08, 32'h2);
    set_sample(1, 16'h5678);
    wr_chk("w1c_coll", 8'h08, 32'h0000_0002, 4'hF, 4'b0010, 2'b00);
    rd_chk("st_set_wins", 8'h08, 32'h0002_0002);
    wr_chk("w1c_ovr1", 8'h08, 32'h0002_0000, 4'hF, '0, 2'b00);
    rd_chk("st_new1_only", 8'h08, 32'h2);
    set_sample(1, 16'h9ABC);
    axil_read(8'h24, 4'b0010, d, r);
    check("rd_coll_old", d, 32'h5678);
    check("rd_coll_resp", 32'(r), 32'd0);
    rd_chk("st_rd_coll", 8'h08, 32'h0002_0002);
    rd_chk("count1", 8'h34, 32'd3);
    wr_chk("w1c_all", 8'h08, 32'hFFFF_FFFF, 4'h0, '0, 2'b00);
    rd_chk("st_all_clr", 8'h08, 32'h0);
    rd_chk("data1_new", 8'h24, 32'h9ABC);

    // interrupt, channel disable, CMD clear
    wr_chk("wr_irq_en", 8'h04, 32'h8, 4'hF, '0, 2'b00);
    check("irq_idle", 32'(irq), 32'd0);
    set_sample(3, 16'h0077);
    strobe(4'b1000);
    check("irq_lag", 32'(irq), 32'd0);
    tick();
    check("irq_rise", 32'(irq), 32'd1);
    wr_chk("ctrl_dis3", 8'h00, 32'h7, 4'hF, '0, 2'b00);
    strobe(4'b1000);
    rd_chk("count3_dis", 8'h3C, 32'd1);
    check("irq_hold", 32'(irq), 32'd1);
    set_sample(0, 16'h0055);
    wr_chk("cmd_clr", 8'h10, 32'h1, 4'h0, 4'b0001, 2'b00);
    check("irq_cmd", 32'(irq), 32'd0);
    for (int i = 0; i < 2 * NUM_CH; i++) rd_chk("cmd_zero", 8'(8'h20 + 4 * i), 32'h0);
    rd_chk("st_cmd", 8'h08, 32'h0);
    rd_chk("ctrl_keep", 8'h00, 32'h7);
    rd_chk("irq_en_keep", 8'h04, 32'h8);

    // unmapped accesses and RO writes
    axil_read(8'hFC, '0, d, r);
    check("rd_fc_resp", 32'(r), 32'd2);
    check("rd_fc_data", d, 32'h0);
    axil_read(8'h40, '0, d, r);
    check("rd_40_resp", 32'(r), 32'd2);
    wr_chk("wr_fc", 8'hFC, 32'hFFFF_FFFF, 4'hF, '0, 2'b10);
    wr_chk("wr_14", 8'h14, 32'hFFFF_FFFF, 4'hF, '0, 2'b10);
    rd_chk("ctrl_after_err", 8'h00, 32'h7);
    wr_chk("wr_id_ro", 8'h0C, 32'h1234_5678, 4'hF, '0, 2'b00);
    rd_chk("id_ro", 8'h0C, VERSION);

    // read back-pressure
    bus.araddr = 8'h0C; bus.arvalid = 1'b1;
    n = 0;
    tick();
    while (!bus.arready && n < 20) begin tick(); n++; end
    check("bp_arready", 32'(bus.arready), 32'd1);
    tick();
    bus.araddr = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", 32'(bus.rvalid), 32'd1);
      check("bp_rdata", bus.rdata, VERSION);
      check("bp_arready_lo", 32'(bus.arready), 32'd0);
      tick();
    end
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("bp_rvalid_drop", 32'(bus.rvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
